// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters: the state encoding,
// the master-count limit and a constant clog2 helper.
package axi_ic_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_ADDR = ADDR,
    ST_RESP = RESP
  } arb_state_e;

  // Returns ceil(log2(v)), with a minimum of 1, so it can be used directly as a port width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick. The search starts at ptr+1 and wraps
// modulo N. The output is the first requesting bit found, as a one-hot
// vector and as a binary index. The data-channel arbiters reuse this block.
module rr_pick
  import axi_ic_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk candidates in priority order (ptr+1 .. ptr+N). The first set bit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && (i == (int'(ptr) + k) % N) && req[i]) begin
          any     = 1'b1;
          pick[i] = 1'b1;
          idx     = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axi_addr_arbiter.sv
// Round-robin arbiter for one AXI address channel (AW or AR).
// The grant is held until the final response handshake, so the channel
// carries at most one outstanding transaction.
// Optional macro ARB_TIMEOUT_EN adds a RESP-state watchdog. When the
// watchdog expires, the grant is released and timeout pulses for one cycle.
module axi_addr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int IDX_W          = clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_ready,
  input  logic                   s_addr_ready,
  input  logic                   s_resp_done,
  output logic                   fwd_valid,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_masters
    $error("axi_addr_arbiter: NUM_MASTERS out of range 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_addr_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  logic            wd_exp;
  assign wd_exp = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (m_req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next-state logic and the handshake outputs. Only the granted master can
  // see fwd_valid or m_ready, so requests from other masters cannot disturb the grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    fwd_valid = 1'b0;
    m_ready   = '0;
`ifdef ARB_TIMEOUT_EN
    wd_d      = wd_q;
    to_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        fwd_valid = m_req[gidx_q];
        if (!fwd_valid) begin
          // The master withdrew its request. Drop the grant and keep the pointer,
          // so the same master still has priority on its next request.
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (s_addr_ready) begin
          m_ready = grant_q;
          state_d = ST_RESP;
`ifdef ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ST_RESP: begin
        if (s_resp_done) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_exp) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and grant registers. An asynchronous reset abandons any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_idx = gidx_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
  assign timeout   = to_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Self-checking bench for axi_addr_arbiter, with 4 masters and a watchdog limit of 16.
// The reference model works at transaction level. The winner is the first requester
// after the last completed master, found with modular arithmetic.
module tb_axi_addr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] m_req;
  logic [3:0] m_ready;
  logic       s_addr_ready;
  logic       s_resp_done;
  logic       fwd_valid;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 3;   // last completed master, as seen by the model

  axi_addr_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_req        (m_req),
    .m_ready      (m_ready),
    .s_addr_ready (s_addr_ready),
    .s_resp_done  (s_resp_done),
    .fwd_valid    (fwd_valid),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int w);
    return 4'(1 << w);
  endfunction

  function automatic int winner(input logic [3:0] m, input int p);
    for (int k = 1; k <= 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_gidx"}, 32'(grant_idx), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fwd"}, 32'(fwd_valid), 0);
    chk({tag, "_mready"}, 32'(m_ready), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // One transaction that starts in IDLE. The task waits rdly cycles before
  // s_addr_ready. It then waits ddly RESP cycles before s_resp_done, unless
  // drop withdraws the request while still in ADDR. extra models other masters
  // raising requests while this one is in flight.
  task automatic txn(input logic [3:0] mask, input int rdly, input int ddly,
                     input bit drop, input logic [3:0] extra, output logic [3:0] g_obs);
    int w;
    w = winner(mask, ptr_m);
    m_req        = mask;
    s_addr_ready = 1'b0;
    s_resp_done  = 1'($urandom_range(0, 1));   // a stale done in IDLE must be ignored
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_fwd", 32'(fwd_valid), 0);
    chk("idle_mready", 32'(m_ready), 0);
    chk("idle_grant", 32'(grant), 0);
    tick();
    s_resp_done = 1'b0;
    g_obs = grant;
    chk("grant", 32'(grant), 32'(oh(w)));
    chk("grant_idx", 32'(grant_idx), 32'(w));
    chk("addr_busy", 32'(busy), 1);
    for (int d = 0; d < rdly; d++) begin
      m_req       = mask | extra;
      s_resp_done = 1'($urandom_range(0, 1));   // ignored in ADDR
      #1;
      chk("wait_fwd", 32'(fwd_valid), 1);
      chk("wait_mready", 32'(m_ready), 0);
      tick();
      chk("wait_grant", 32'(grant), 32'(oh(w)));
    end
    s_resp_done = 1'b0;
    if (drop) begin
      m_req        = (mask | extra) & ~oh(w);
      s_addr_ready = 1'($urandom_range(0, 1));
      #1;
      chk("drop_fwd", 32'(fwd_valid), 0);
      chk("drop_mready", 32'(m_ready), 0);
      tick();
      chk("drop_busy", 32'(busy), 0);
      chk("drop_grant", 32'(grant), 0);
      chk("drop_gidx", 32'(grant_idx), 32'(w));
      m_req        = '0;
      s_addr_ready = 1'b0;
      return;
    end
    s_addr_ready = 1'b1;
    #1;
    chk("hs_fwd", 32'(fwd_valid), 1);
    chk("hs_mready", 32'(m_ready), 32'(oh(w)));
    tick();
    s_addr_ready = 1'b0;
    m_req        = (mask | extra) & ~oh(w);
    for (int d = 0; d < ddly; d++) begin
      #1;
      chk("resp_busy", 32'(busy), 1);
      chk("resp_fwd", 32'(fwd_valid), 0);
      chk("resp_mready", 32'(m_ready), 0);
      chk("resp_grant", 32'(grant), 32'(oh(w)));
      chk("resp_timeout", 32'(timeout), 0);
      tick();
    end
    s_resp_done = 1'b1;
    #1;
    chk("done_busy", 32'(busy), 1);
    tick();
    s_resp_done = 1'b0;
    m_req       = '0;
    chk("end_busy", 32'(busy), 0);
    chk("end_grant", 32'(grant), 0);
    chk("end_gidx", 32'(grant_idx), 32'(w));
    chk("end_timeout", 32'(timeout), 0);
    ptr_m = w;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] rot_exp [5];
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; m_req = '0; s_addr_ready = 1'b0; s_resp_done = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single transaction from master 0. Busy lasts 5 cycles: 1 in ADDR, 4 in RESP.
    txn(4'b0001, 0, 3, 1'b0, 4'b0000, g);

    // Master 1 rises while master 0 waits 10 cycles in ADDR. No preemption.
    txn(4'b0001, 10, 2, 1'b0, 4'b0010, g);
    chk("after_wait_winner", 32'(g), 32'(4'b0001));
    txn(4'b0011, 0, 1, 1'b0, 4'b0000, g);
    chk("m1_next", 32'(g), 32'(4'b0010));

    // Master 2 drops its request in ADDR. The pointer stays put, so master 2 wins again.
    txn(4'b0101, 1, 0, 1'b1, 4'b0000, g);
    chk("drop_first", 32'(g), 32'(4'b0100));
    txn(4'b0101, 0, 0, 1'b0, 4'b0000, g);
    chk("drop_rewin", 32'(g), 32'(4'b0100));

`ifdef ARB_TIMEOUT_EN
    // No s_resp_done arrives. timeout pulses 16 cycles after RESP entry.
    begin
      int w;
      w = winner(4'b0010, ptr_m);
      m_req = 4'b0010; s_addr_ready = 1'b1;
      tick();
      chk("to_grant", 32'(grant), 32'(oh(w)));
      tick();
      m_req = '0; s_addr_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
        #1;
        chk("to_pre", 32'(timeout), 0);
        chk("to_pre_busy", 32'(busy), 1);
        tick();
      end
      chk("to_pulse", 32'(timeout), 1);
      chk("to_grant_rel", 32'(grant), 0);
      chk("to_busy", 32'(busy), 0);
      ptr_m = w;
      tick();
      chk("to_one_cycle", 32'(timeout), 0);
    end
    // s_resp_done lands on the expiry cycle. The done wins and no timeout pulses.
    txn(4'b1111, 0, 15, 1'b0, 4'b0000, g);
`else
    // Without the watchdog, RESP waits indefinitely.
    txn(4'b1111, 0, 40, 1'b0, 4'b0000, g);
`endif

    // Asynchronous reset in RESP. A stale done after the release is ignored.
    m_req = 4'b0100; s_addr_ready = 1'b1;
    tick();
    tick();
    m_req = '0; s_addr_ready = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst_n = 1'b1; s_resp_done = 1'b1;
    tick();
    s_resp_done = 1'b0;
    chk("stale_busy", 32'(busy), 0);
    chk("stale_grant", 32'(grant), 0);
    tick();
    chk("stale_grant2", 32'(grant), 0);
    ptr_m = 3;

    // All four masters request continuously. Grants follow strict rotation from master 0.
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, i % 2, 1, 1'b0, 4'b0000, g);
      chk("rotation", 32'(g), 32'(rot_exp[i]));
    end

    // Randomized transactions checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] mask, extra;
      int rd, dd;
      bit dr;
      mask  = 4'($urandom_range(1, 15));
      extra = 4'($urandom_range(0, 15));
      rd    = int'($urandom_range(0, 3));
      dd    = int'($urandom_range(0, 12));
      dr    = ($urandom_range(0, 7) == 0);
      txn(mask, rd, dd, dr, extra, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
